// File: rtl/bus_pack_capture.sv
// bus_pack_capture: latches request header/offset/size and packs the addressed sub-word of read data, replicated across the response bus
module bus_pack_capture #(
    parameter int in_width_p     = 32,
    parameter int out_width_p    = 64,
    parameter int header_width_p = 16,
    localparam int lg_bytes_lp   = $clog2(in_width_p / 8),
    localparam int size_width_lp = $clog2(lg_bytes_lp + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      v_i,
    input  logic [header_width_p-1:0] header_i,
    input  logic [lg_bytes_lp-1:0]    sel_i,
    input  logic [size_width_lp-1:0]  size_i,
    input  logic [in_width_p-1:0]     data_i,
    output logic [header_width_p-1:0] header_o,
    output logic [lg_bytes_lp-1:0]    sel_o,
    output logic [size_width_lp-1:0]  size_o,
    output logic [out_width_p-1:0]    data_o
);

    if (in_width_p != 32 && in_width_p != 64) begin : g_bad_in
        $error("in_width_p must be 32 or 64");
    end
    if (out_width_p < in_width_p || out_width_p % in_width_p != 0) begin : g_bad_out
        $error("out_width_p must be a multiple of in_width_p");
    end

    // capture register: async clear, load on v_i, otherwise hold
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            header_o <= '0;
            sel_o    <= '0;
            size_o   <= '0;
        end else if (v_i) begin
            header_o <= header_i;
            sel_o    <= sel_i;
            size_o   <= size_i;
        end
    end

    // one replicated candidate per size code; codes beyond the word size collapse to the full word
    logic [out_width_p-1:0] rep [2**size_width_lp];

    for (genvar k = 0; k < 2**size_width_lp; k++) begin : g_sz
        localparam int kk    = (k > lg_bytes_lp) ? lg_bytes_lp : k;
        localparam int seg_w = 8 << kk;
        localparam int n_seg = in_width_p / seg_w;
        logic [n_seg-1:0][seg_w-1:0] segs;
        logic [seg_w-1:0]            seg;
        assign segs = data_i;
        if (kk < lg_bytes_lp) begin : g_idx
            assign seg = segs[sel_o[lg_bytes_lp-1:kk]];
        end else begin : g_full
            assign seg = segs[0];
        end
        assign rep[k] = {(out_width_p / seg_w){seg}};
    end

    assign data_o = rep[size_o];

endmodule

// File: tb/tb_bus_pack_capture.sv
// tb_bus_pack_capture: directed checks of capture, packing, hold and async reset
module tb_bus_pack_capture;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        v = 1'b0;
    logic [15:0] header_in = '0;
    logic [1:0]  sel_in = '0;
    logic [1:0]  size_in = '0;
    logic [31:0] data_in = 32'hAABBCCDD;
    logic [15:0] header_out;
    logic [1:0]  sel_out;
    logic [1:0]  size_out;
    logic [63:0] data_out;

    int errors = 0;
    int checks = 0;

    bus_pack_capture #(
        .in_width_p(32),
        .out_width_p(64),
        .header_width_p(16)
    ) dut (
        .clk_i(clk),
        .reset_n_i(reset_n),
        .v_i(v),
        .header_i(header_in),
        .sel_i(sel_in),
        .size_i(size_in),
        .data_i(data_in),
        .header_o(header_out),
        .sel_o(sel_out),
        .size_o(size_out),
        .data_o(data_out)
    );

    always #5 clk = ~clk;

    // load one request and return 1 time unit after the capturing edge
    task automatic capture(input logic [15:0] h, input logic [1:0] s, input logic [1:0] z);
        header_in = h;
        sel_in    = s;
        size_in   = z;
        v         = 1'b1;
        @(posedge clk);
        #1;
        v = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (header_out !== 16'h0) begin
            errors++;
            $display("FAIL reset_header got=%h want=%h", header_out, 16'h0);
        end
        checks++;
        if (sel_out !== 2'd0) begin
            errors++;
            $display("FAIL reset_sel got=%h want=%h", sel_out, 2'd0);
        end
        checks++;
        if (size_out !== 2'd0) begin
            errors++;
            $display("FAIL reset_size got=%h want=%h", size_out, 2'd0);
        end
        checks++;
        if (data_out !== 64'hDDDDDDDDDDDDDDDD) begin
            errors++;
            $display("FAIL reset_data got=%h want=%h", data_out, 64'hDDDDDDDDDDDDDDDD);
        end
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_byte;
        capture(16'h0001, 2'd1, 2'd0);
        checks++;
        if (data_out !== 64'hCCCCCCCCCCCCCCCC) begin
            errors++;
            $display("FAIL byte_sel1 got=%h want=%h", data_out, 64'hCCCCCCCCCCCCCCCC);
        end
        capture(16'h0002, 2'd3, 2'd0);
        checks++;
        if (data_out !== 64'hAAAAAAAAAAAAAAAA) begin
            errors++;
            $display("FAIL byte_sel3 got=%h want=%h", data_out, 64'hAAAAAAAAAAAAAAAA);
        end
        capture(16'h0003, 2'd0, 2'd0);
        checks++;
        if (data_out !== 64'hDDDDDDDDDDDDDDDD) begin
            errors++;
            $display("FAIL byte_sel0 got=%h want=%h", data_out, 64'hDDDDDDDDDDDDDDDD);
        end
    endtask

    task automatic test_half;
        capture(16'h0010, 2'd2, 2'd1);
        checks++;
        if (data_out !== 64'hAABBAABBAABBAABB) begin
            errors++;
            $display("FAIL half_sel2 got=%h want=%h", data_out, 64'hAABBAABBAABBAABB);
        end
        capture(16'h0011, 2'd3, 2'd1);
        checks++;
        if (data_out !== 64'hAABBAABBAABBAABB) begin
            errors++;
            $display("FAIL half_sel3 got=%h want=%h", data_out, 64'hAABBAABBAABBAABB);
        end
        capture(16'h0012, 2'd1, 2'd1);
        checks++;
        if (data_out !== 64'hCCDDCCDDCCDDCCDD) begin
            errors++;
            $display("FAIL half_sel1 got=%h want=%h", data_out, 64'hCCDDCCDDCCDDCCDD);
        end
    endtask

    task automatic test_word;
        capture(16'h0020, 2'd1, 2'd2);
        checks++;
        if (data_out !== 64'hAABBCCDDAABBCCDD) begin
            errors++;
            $display("FAIL word_size2 got=%h want=%h", data_out, 64'hAABBCCDDAABBCCDD);
        end
        capture(16'h0021, 2'd3, 2'd3);
        checks++;
        if (data_out !== 64'hAABBCCDDAABBCCDD) begin
            errors++;
            $display("FAIL word_size3 got=%h want=%h", data_out, 64'hAABBCCDDAABBCCDD);
        end
        checks++;
        if (size_out !== 2'd3 || sel_out !== 2'd3 || header_out !== 16'h0021) begin
            errors++;
            $display("FAIL word_fields got=%h/%h/%h want=0021/3/3", header_out, sel_out, size_out);
        end
    endtask

    task automatic test_hold;
        capture(16'h1234, 2'd1, 2'd0);
        header_in = 16'hFFFF;
        sel_in    = 2'd2;
        size_in   = 2'd2;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (header_out !== 16'h1234 || data_out !== 64'hCCCCCCCCCCCCCCCC) begin
                errors++;
                $display("FAIL hold_cycle%0d got=%h/%h want=1234/cccccccccccccccc", i, header_out, data_out);
            end
        end
        data_in = 32'h11223344;
        #1;
        checks++;
        if (data_out !== 64'h3333333333333333) begin
            errors++;
            $display("FAIL hold_newdata got=%h want=%h", data_out, 64'h3333333333333333);
        end
        data_in = 32'hAABBCCDD;
        #1;
    endtask

    task automatic test_same_cycle;
        header_in = 16'h0040;
        sel_in    = 2'd0;
        size_in   = 2'd2;
        v         = 1'b1;
        data_in   = 32'h55667788;
        #1;
        checks++;
        if (data_out !== 64'h7777777777777777) begin
            errors++;
            $display("FAIL same_cycle_before got=%h want=%h", data_out, 64'h7777777777777777);
        end
        @(posedge clk);
        #1;
        v = 1'b0;
        checks++;
        if (data_out !== 64'h5566778855667788) begin
            errors++;
            $display("FAIL same_cycle_after got=%h want=%h", data_out, 64'h5566778855667788);
        end
        data_in = 32'hAABBCCDD;
    endtask

    task automatic test_async_reset;
        capture(16'hBEEF, 2'd2, 2'd2);
        checks++;
        if (data_out !== 64'hAABBCCDDAABBCCDD) begin
            errors++;
            $display("FAIL async_pre got=%h want=%h", data_out, 64'hAABBCCDDAABBCCDD);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (size_out !== 2'd0 || data_out !== 64'hDDDDDDDDDDDDDDDD) begin
            errors++;
            $display("FAIL async_mid got=%h/%h want=0/dddddddddddddddd", size_out, data_out);
        end
        #2;
        reset_n = 1'b1;
        header_in = 16'h7777;
        sel_in    = 2'd3;
        size_in   = 2'd1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (header_out !== 16'h0 || sel_out !== 2'd0 || size_out !== 2'd0 || data_out !== 64'hDDDDDDDDDDDDDDDD) begin
            errors++;
            $display("FAIL async_after got=%h/%h/%h/%h want=0/0/0/dddddddddddddddd", header_out, sel_out, size_out, data_out);
        end
        capture(16'h7777, 2'd3, 2'd1);
        checks++;
        if (header_out !== 16'h7777 || data_out !== 64'hAABBAABBAABBAABB) begin
            errors++;
            $display("FAIL async_recapture got=%h/%h want=7777/aabbaabbaabbaabb", header_out, data_out);
        end
    endtask

    initial begin
        test_reset();
        test_byte();
        test_half();
        test_word();
        test_hold();
        test_same_cycle();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_pack_capture.md
Name:
bus_pack_capture

Overview:
- Read-response data formatter for narrow bus bridges.
- Latches a request's byte offset, size and an opaque header when a request is accepted.
- Combinationally extracts the addressed sub-word from a wide read-data bus, using the latched offset and size.
- Replicates that sub-word across a response bus at least as wide as the read bus. Sits between an AXI4-Lite-style read-data channel and a packet response channel.

Parameters:
- in_width_p, 32, read-data bus width in bits; legal values 32 or 64.
- out_width_p, 64, response data width in bits; must be ≥ in_width_p and an integer multiple of it (elaboration error otherwise).
- header_width_p, 16, width of the opaque header captured alongside offset and size.
- lg_bytes_lp (derived), clog2(in_width_p/8), width of the byte-offset field.
- size_width_lp (derived), clog2(lg_bytes_lp+1), width of the size field (log2 of the byte count).

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- v_i  in  1  capture enable; a high level at a clock edge latches header_i, sel_i and size_i.
- header_i  in  header_width_p  opaque request header.
- sel_i  in  lg_bytes_lp  request byte offset within an in_width_p word.
- size_i  in  size_width_lp  log2 of request byte count.
- data_i  in  in_width_p  raw read data; byte 0 is bits [7:0].
- header_o  out  header_width_p  latched header.
- sel_o  out  lg_bytes_lp  latched offset.
- size_o  out  size_width_lp  latched size.
- data_o  out  out_width_p  packed, replicated read data.

Behaviour:
- Capture register:
  - One register holds {header, sel, size}.
  - reset_n_i low → register cleared to all zeros immediately, independent of the clock. This takes priority over v_i.
  - Otherwise, on a rising edge with v_i=1 the register loads the inputs; with v_i=0 it holds its value.
  - header_o, sel_o and size_o drive the register directly: they change one cycle after capture, and there is no combinational path from header_i, sel_i or size_i.
- Pack function: fully combinational from data_i and the registered sel/size (zero-cycle latency from data_i).
  - s = min(size_o, lg_bytes_lp). A size_o value larger than lg_bytes_lp selects the full word.
  - Aligned offset a = sel_o with its low s bits cleared. Misaligned offsets round down.
  - Segment = data_i bits [8·a +: 8·2^s].
  - data_o = segment replicated out_width_p/(8·2^s) times, filling out_width_p exactly.
- Boundary conditions:
  - During and after reset, sel_o=0 and size_o=0, so data_o = data_i[7:0] replicated.
  - A capture and a data_i change in the same cycle: data_o uses the old sel/size until the edge, then the new ones.
  - Reset asserted mid-transaction: outputs revert to the zero-field behaviour within the same cycle. No X ever appears on an output once reset has been asserted.
- No internal state other than the capture register; no handshake outputs. Flow control belongs to the enclosing FSM.

Test Plan:
All cases use in=32, out=64, data_i=0xAABBCCDD.
- Reset: reset_n_i=0 asynchronously → header_o=0, sel_o=0, size_o=0, data_o=0xDDDDDDDDDDDDDDDD without waiting for a clock edge.
- Byte: capture sel=1, size=0 → next cycle data_o=0xCCCCCCCCCCCCCCCC. Repeat with sel=3 → 0xAAAAAAAAAAAAAAAA.
- Half-word: capture sel=2, size=1 → 0xAABBAABBAABBAABB. Repeat with sel=3 (misaligned) → same value.
- Word: size=2 with any sel → 0xAABBCCDDAABBCCDD. Oversize size=3 → same value.
- Hold: after capturing header=0x1234, sel=1, size=0, drive v_i=0 with new inputs for 5 cycles → header_o stays 0x1234 and data_o stays 0xCCCC…CC. Changing data_i to 0x11223344 gives 0x3333333333333333 in the same cycle.
- Async reset mid-operation: assert reset_n_i between clock edges while size=2 is latched → size_o drops to 0 and data_o becomes 0xDDDD…DD before the next edge. After deassertion, the register holds zeros until the next v_i.
